core_job_sequencer: RTL and testbench

//  Wishbone master that runs one inference job on CORE_TOP without software involvement.

---
 rtl/core_job_sequencer_if.sv | 25 ++
 rtl/core_job_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_core_job_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_job_sequencer_if.sv
// rtl/core_job_sequencer_if.sv - Wishbone-style master/slave bus between the job sequencer and CORE_TOP
interface core_job_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cyc;
    logic             stb;
    logic             we;
    logic             sel;
    logic [31:0]      addr;
    logic [WIDTH-1:0] wdata;
    logic             stall;
    logic             ack;
    logic             err;
    logic [WIDTH-1:0] rdata;

    modport master (
        output cyc, stb, we, sel, addr, wdata,
        input  stall, ack, err, rdata
    );

    modport slave (
        input  cyc, stb, we, sel, addr, wdata,
        output stall, ack, err, rdata
    );
endinterface

// File: rtl/core_job_sequencer.sv
// rtl/core_job_sequencer.sv - runs one CORE_TOP inference job: load grid, trigger, poll, read solution
module core_job_sequencer #(
    parameter int          NUM_INPUTS      = 16,
    parameter int          WIDTH           = 8,
    parameter logic [14:0] GRID_OFFSET     = 15'h0000,
    parameter logic [14:0] CTRL_OFFSET     = 15'h0010,
    parameter logic [14:0] STATUS_OFFSET   = 15'h0011,
    parameter logic [14:0] SOLUTION_OFFSET = 15'h0012,
    parameter int          MAX_POLLS       = 1000,
    parameter int          POLL_GAP        = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_INPUTS*WIDTH-1:0] grid,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            result,
    output logic [1:0]                  err_code,
    core_job_sequencer_if.master        wb
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CTRL_RD, S_TRIG_SET, S_TRIG_CLR,
        S_POLL_WAIT, S_POLL, S_SOL_RD, S_DONE
    } state_t;

    localparam int IW  = $clog2(NUM_INPUTS + 1);
    localparam int PCW = ($clog2(MAX_POLLS + 1) < 10) ? 10 : $clog2(MAX_POLLS + 1);
    localparam int GW  = $clog2(POLL_GAP + 2);
    localparam logic [GW-1:0] GAP_LOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_t                      state;
    logic [NUM_INPUTS*WIDTH-1:0] grid_q;
    logic [IW-1:0]               idx;
    logic [PCW-1:0]              poll_cnt;
    logic [PCW-1:0]              poll_nxt;
    logic [GW-1:0]               gap_cnt;
    logic [WIDTH-1:0]            ctrl_shadow;
    logic                        cyc_q;
    logic                        stb_q;
    logic                        we_q;
    logic [31:0]                 addr_q;
    logic [WIDTH-1:0]            wdata_q;
    logic                        acc_we;
    logic [14:0]                 acc_off;
    logic [WIDTH-1:0]            acc_wdata;

    function automatic logic [31:0] wb_addr(input logic [14:0] off);
        return {14'd0, 1'b1, off, 2'b00};
    endfunction

    // Access descriptor for whichever bus state we are in; issued only when the bus is idle.
    always_comb begin
        acc_we    = 1'b0;
        acc_off   = STATUS_OFFSET;
        acc_wdata = '0;
        case (state)
            S_LOAD: begin
                acc_we    = 1'b1;
                acc_off   = GRID_OFFSET + 15'(idx);
                acc_wdata = grid_q[idx*WIDTH +: WIDTH];
            end
            S_CTRL_RD:  acc_off = CTRL_OFFSET;
            S_TRIG_SET: begin
                acc_we    = 1'b1;
                acc_off   = CTRL_OFFSET;
                acc_wdata = ctrl_shadow | WIDTH'(2);
            end
            S_TRIG_CLR: begin
                acc_we    = 1'b1;
                acc_off   = CTRL_OFFSET;
                acc_wdata = ctrl_shadow & ~WIDTH'(2);
            end
            S_SOL_RD:   acc_off = SOLUTION_OFFSET;
            default:    acc_off = STATUS_OFFSET;
        endcase
    end

    assign poll_nxt = (poll_cnt == '1) ? poll_cnt : poll_cnt + 1'b1;

    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign wb.we    = we_q;
    assign wb.sel   = cyc_q;
    assign wb.addr  = addr_q;
    assign wb.wdata = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            grid_q      <= '0;
            idx         <= '0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            ctrl_shadow <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            err_code    <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        grid_q   <= grid;
                        busy     <= 1'b1;
                        idx      <= '0;
                        poll_cnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_POLL_WAIT: begin
                    if (gap_cnt == '0) state <= S_POLL;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (!cyc_q) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= acc_we;
                        addr_q  <= wb_addr(acc_off);
                        wdata_q <= acc_wdata;
                    end else begin
                        if (stb_q && !wb.stall) stb_q <= 1'b0;
                        if (wb.err || wb.ack) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            we_q  <= 1'b0;
                        end
                        if (wb.err) begin
                            err_code <= 2'b10;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_DONE;
                        end else if (wb.ack) begin
                            case (state)
                                S_LOAD: begin
                                    if (idx == IW'(NUM_INPUTS - 1)) state <= S_CTRL_RD;
                                    else                            idx   <= idx + 1'b1;
                                end
                                S_CTRL_RD: begin
                                    ctrl_shadow <= wb.rdata;
                                    state       <= S_TRIG_SET;
                                end
                                S_TRIG_SET: state <= S_TRIG_CLR;
                                S_TRIG_CLR: begin
                                    gap_cnt <= GAP_LOAD;
                                    state   <= S_POLL_WAIT;
                                end
                                S_POLL: begin
                                    if (wb.rdata[0]) begin
                                        state <= S_SOL_RD;
                                    end else begin
                                        poll_cnt <= poll_nxt;
                                        if (poll_nxt == PCW'(MAX_POLLS)) begin
                                            err_code <= 2'b01;
                                            done     <= 1'b1;
                                            busy     <= 1'b0;
                                            state    <= S_DONE;
                                        end else begin
                                            gap_cnt <= GAP_LOAD;
                                            state   <= S_POLL_WAIT;
                                        end
                                    end
                                end
                                S_SOL_RD: begin
                                    result   <= wb.rdata;
                                    err_code <= 2'b00;
                                    done     <= 1'b1;
                                    busy     <= 1'b0;
                                    state    <= S_DONE;
                                end
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_job_sequencer.sv
// tb/tb_core_job_sequencer.sv - directed bench for core_job_sequencer with a Wishbone slave model and access scoreboard
module tb_core_job_sequencer;
    localparam logic [14:0] GRID_OFF = 15'h0100;
    localparam logic [14:0] CTRL_OFF = 15'h0000;
    localparam logic [14:0] STAT_OFF = 15'h0001;
    localparam logic [14:0] SOL_OFF  = 15'h0002;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] grid = '0;
    logic         busy;
    logic         done;
    logic [7:0]   result;
    logic [1:0]   err_code;

    core_job_sequencer_if #(.WIDTH(8)) wb ();

    core_job_sequencer #(
        .NUM_INPUTS(16), .WIDTH(8),
        .GRID_OFFSET(GRID_OFF), .CTRL_OFFSET(CTRL_OFF),
        .STATUS_OFFSET(STAT_OFF), .SOLUTION_OFFSET(SOL_OFF),
        .MAX_POLLS(1000), .POLL_GAP(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .grid(grid),
        .busy(busy), .done(done), .result(result), .err_code(err_code),
        .wb(wb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input logic [14:0] off);
        return 32'h0002_0000 | (32'(off) << 2);
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Slave model configuration (written by the stimulus) and counters (written by the slave).
    logic [7:0]  ctrl_val = 8'h00;
    logic [7:0]  sol_val  = 8'h00;
    int          err_at = -1;
    int          stall_at = -1;
    int          ready_abs = 0;
    int          acc_idx = 0;
    int          status_reads = 0;
    int          sol_reads = 0;
    int          stall_cnt = 0;
    int          stb_hold = 0;
    int          done_cnt = 0;
    logic [40:0] obs_q[$];
    logic [40:0] exp_q[$];

    assign wb.stall = (stall_at >= 0) && wb.cyc && wb.stb && (acc_idx == stall_at) && (stall_cnt < 5);

    always @(posedge clk) begin
        wb.ack <= 1'b0;
        wb.err <= 1'b0;
        if (wb.stall) stall_cnt <= stall_cnt + 1;
        if (wb.cyc && wb.stb && acc_idx == stall_at) stb_hold <= stb_hold + 1;
        if (wb.cyc && wb.stb && !wb.stall) begin
            obs_q.push_back({wb.we, wb.addr, wb.we ? wb.wdata : 8'h00});
            acc_idx <= acc_idx + 1;
            if (acc_idx == err_at) wb.err <= 1'b1;
            else                   wb.ack <= 1'b1;
            if (!wb.we && wb.addr == addr_of(CTRL_OFF)) begin
                wb.rdata <= ctrl_val;
            end else if (!wb.we && wb.addr == addr_of(STAT_OFF)) begin
                wb.rdata     <= (status_reads >= ready_abs) ? 8'h01 : 8'h00;
                status_reads <= status_reads + 1;
            end else if (!wb.we && wb.addr == addr_of(SOL_OFF)) begin
                wb.rdata  <= sol_val;
                sol_reads <= sol_reads + 1;
            end
        end
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    // ready_n = 0 means STATUS never reports ready.
    task automatic run_job(input string name, input logic [127:0] g, input logic [7:0] ctrl_v,
                           input int ready_n, input logic [7:0] sol_v, input int err_idx,
                           input int stall_idx, input bit collide,
                           input logic [7:0] exp_result, input logic [1:0] exp_err, output int lat);
        int  base;
        int  dbase;
        int  n_status;
        bit  seen;
        base      = obs_q.size();
        dbase     = done_cnt;
        ctrl_val  = ctrl_v;
        sol_val   = sol_v;
        err_at    = (err_idx < 0) ? -1 : base + err_idx;
        stall_at  = (stall_idx < 0) ? -1 : base + stall_idx;
        ready_abs = (ready_n == 0) ? 32'h7fff_ffff : status_reads + ready_n - 1;
        n_status  = (ready_n == 0) ? 1000 : ready_n;

        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (err_idx >= 0 && i > err_idx) break;
            exp_q.push_back({1'b1, addr_of(GRID_OFF + 15'(i)), g[i*8 +: 8]});
        end
        if (err_idx < 0) begin
            exp_q.push_back({1'b0, addr_of(CTRL_OFF), 8'h00});
            exp_q.push_back({1'b1, addr_of(CTRL_OFF), ctrl_v | 8'h02});
            exp_q.push_back({1'b1, addr_of(CTRL_OFF), ctrl_v & 8'hFD});
            for (int i = 0; i < n_status; i++) exp_q.push_back({1'b0, addr_of(STAT_OFF), 8'h00});
            if (ready_n != 0) exp_q.push_back({1'b0, addr_of(SOL_OFF), 8'h00});
        end

        @(negedge clk);
        grid  = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " busy after start"}, 64'(busy), 64'd1);
        seen = 1'b0;
        lat  = 1;
        while (!seen && lat < 20000) begin
            start = collide && (lat == 30);
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
        end
        check({name, " done seen"}, 64'(seen), 64'd1);
        check({name, " busy in done cycle"}, 64'(busy), 64'd0);
        check({name, " result"}, 64'(result), 64'(exp_result));
        check({name, " err_code"}, 64'(err_code), 64'(exp_err));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " done one cycle"}, 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        check({name, " done pulses"}, 64'(done_cnt - dbase), 64'd1);
        check({name, " access count"}, 64'(obs_q.size() - base), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++)
            check($sformatf("%s access %0d", name, k), 64'(obs_q[base + k]), 64'(exp_q[k]));
    endtask

    initial begin
        logic [127:0] g;
        int           lat;
        int           w;
        int           base;
        int           dbase;
        int           sr0;
        int           so0;

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset cyc", 64'(wb.cyc), 64'd0);
        check("reset stb", 64'(wb.stb), 64'd0);
        check("reset we", 64'(wb.we), 64'd0);
        check("reset sel", 64'(wb.sel), 64'd0);
        check("reset addr", 64'(wb.addr), 64'd0);
        check("reset wdata", 64'(wb.wdata), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset err_code", 64'(err_code), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) g[i*8 +: 8] = 8'(i + 1);
        sr0 = status_reads;
        so0 = sol_reads;
        run_job("nominal", g, 8'h00, 3, 8'h03, -1, -1, 1'b0, 8'h03, 2'b00, lat);
        check("nominal status reads", 64'(status_reads - sr0), 64'd3);
        check("nominal solution reads", 64'(sol_reads - so0), 64'd1);

        for (int i = 0; i < 16; i++) g[i*8 +: 8] = 8'($urandom_range(0, 255));
        run_job("stall", g, 8'h00, 1, 8'h5A, -1, 7, 1'b0, 8'h5A, 2'b00, lat);
        check("stall cycles", 64'(stall_cnt), 64'd5);
        check("stall stb held", 64'(stb_hold), 64'd6);
        check("latency lower bound", 64'(lat >= 2 * (16 + 4) + 4 + 2), 64'd1);

        for (int i = 0; i < 16; i++) g[i*8 +: 8] = 8'(8'hF0 - i);
        sr0 = status_reads;
        so0 = sol_reads;
        run_job("timeout", g, 8'h00, 0, 8'hEE, -1, -1, 1'b0, 8'h5A, 2'b01, lat);
        check("timeout status reads", 64'(status_reads - sr0), 64'd1000);
        check("timeout solution reads", 64'(sol_reads - so0), 64'd0);

        run_job("buserr", g, 8'h00, 1, 8'hEE, 4, -1, 1'b0, 8'h5A, 2'b10, lat);

        for (int i = 0; i < 16; i++) g[i*8 +: 8] = 8'(8'h30 + 3 * i);
        run_job("ctrl_collide", g, 8'h04, 2, 8'h77, -1, -1, 1'b1, 8'h77, 2'b00, lat);

        base      = obs_q.size();
        dbase     = done_cnt;
        err_at    = -1;
        stall_at  = -1;
        ready_abs = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(wb.cyc && wb.stb && obs_q.size() >= base + 3) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("reset wait for LOAD access", 64'(w < 200), 64'd1);
        check("sel during access", 64'(wb.sel), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("midjob reset cyc", 64'(wb.cyc), 64'd0);
        check("midjob reset stb", 64'(wb.stb), 64'd0);
        check("midjob reset busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("midjob reset no done", 64'(done_cnt - dbase), 64'd0);
        check("midjob reset no accesses", 64'(obs_q.size() - base), 64'd3);
        check("midjob reset idle busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
